tick_generator: RTL and testbench

- Programmable periodic/one-shot tick source. It produces the `counter_tick` event stream consumed by the rising-edge-counting down counter and by other tick-driven peripherals.
- Exposes two register-file words: period (read/write) and control/status (write control, read status). Both share the peripheral's `data_in` bus.
- Sits beside the down counter in the synapse peripheral set and is clocked by `sysclk`.

---
 rtl/tick_generator.sv | 112 +++++++++++
 tb/tb_tick_generator.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/tick_generator.sv
// tick_generator: programmable periodic / one-shot tick source.
// Optional square-wave output mode is built when TICK_GEN_SQUARE_EN is defined;
// without it, control bit[2] is ignored and reads back 0.
module tick_generator #(
  parameter int WIDTH = 16
) (
  input  logic             sysclk,
  input  logic             sysreset_n,
  input  logic [WIDTH-1:0] data_in,
  input  logic             period_load,
  output logic [WIDTH-1:0] period_data_out,
  input  logic             control_load,
  output logic [WIDTH-1:0] status_data_out,
  output logic             tick_out
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t           state;
  logic [WIDTH-1:0] period_q;
  logic [WIDTH-1:0] period_next;
  logic [WIDTH-1:0] cnt;
  logic             oneshot_q;
  logic             square_q;
  logic             fired_q;
  logic             running;

  // A restart uses the period written on the same edge, if any.
  always_comb begin
    period_next = period_q;
    if (period_load) begin
      period_next = data_in;
    end
  end

  always_ff @(posedge sysclk or negedge sysreset_n) begin
    if (!sysreset_n) begin
      period_q <= '0;
    end else if (period_load) begin
      period_q <= data_in;
    end
  end

`ifdef TICK_GEN_SQUARE_EN
  always_ff @(posedge sysclk or negedge sysreset_n) begin
    if (!sysreset_n) begin
      square_q <= 1'b0;
    end else if (control_load) begin
      square_q <= data_in[2];
    end
  end
`else
  assign square_q = 1'b0;
`endif

  // Reload uses the registered period, so a period write only affects the
  // next interval and never the one currently counting.
  always_ff @(posedge sysclk or negedge sysreset_n) begin
    if (!sysreset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      tick_out  <= 1'b0;
      fired_q   <= 1'b0;
      oneshot_q <= 1'b0;
    end else if (control_load) begin
      oneshot_q <= data_in[1];
      fired_q   <= 1'b0;
      tick_out  <= 1'b0;
      if (data_in[0] && (period_next != '0)) begin
        state <= RUN;
        cnt   <= period_next - ONE;
      end else begin
        state <= IDLE;
        cnt   <= '0;
      end
    end else begin
      case (state)
        RUN: begin
          if (cnt == '0) begin
            fired_q  <= 1'b1;
            tick_out <= square_q ? ~tick_out : 1'b1;
            if (oneshot_q || (period_q == '0)) begin
              state <= IDLE;
              cnt   <= '0;
            end else begin
              cnt <= period_q - ONE;
            end
          end else begin
            cnt <= cnt - ONE;
            if (!square_q) begin
              tick_out <= 1'b0;
            end
          end
        end
        default: begin
          cnt      <= '0;
          tick_out <= 1'b0;
        end
      endcase
    end
  end

  assign running         = (state == RUN);
  assign period_data_out = period_q;
  assign status_data_out = {{(WIDTH-4){1'b0}}, fired_q, square_q, oneshot_q, running};

endmodule

// File: tb/tb_tick_generator.sv
// Directed bench for tick_generator (default build, pulse mode).
module tb_tick_generator;

  logic        sysclk = 1'b0;
  logic        sysreset_n;
  logic [15:0] data_in;
  logic        period_load;
  logic [15:0] period_data_out;
  logic        control_load;
  logic [15:0] status_data_out;
  logic        tick_out;

  int unsigned compared   = 0;
  int unsigned mismatched = 0;
  bit          exp_q[$];

  tick_generator #(.WIDTH(16)) dut (
    .sysclk          (sysclk),
    .sysreset_n      (sysreset_n),
    .data_in         (data_in),
    .period_load     (period_load),
    .period_data_out (period_data_out),
    .control_load    (control_load),
    .status_data_out (status_data_out),
    .tick_out        (tick_out)
  );

  always #5 sysclk = ~sysclk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock; compares tick_out against the scoreboard when an entry is due.
  task automatic cycle();
    bit e;
    @(posedge sysclk);
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("tick_out", 16'(tick_out), 16'(e));
    end
  endtask

  task automatic drain();
    while (exp_q.size() > 0) cycle();
  endtask

  // Expected tick_out for cycles 1..n after a control write with period p.
  task automatic push_trace(input int n, input int p, input bit one);
    for (int k = 1; k <= n; k++) begin
      exp_q.push_back(one ? (k == p) : ((k % p) == 0));
    end
  endtask

  task automatic push_zeros(input int n);
    for (int k = 0; k < n; k++) exp_q.push_back(1'b0);
  endtask

  task automatic wr(input bit pl, input bit cl, input logic [15:0] d);
    @(negedge sysclk);
    data_in      = d;
    period_load  = pl;
    control_load = cl;
    cycle();
    period_load  = 1'b0;
    control_load = 1'b0;
  endtask

  initial begin
    int  rises;
    bit  prev;

    sysreset_n   = 1'b0;
    data_in      = '0;
    period_load  = 1'b0;
    control_load = 1'b0;
    repeat (2) @(posedge sysclk);
    #1;
    chk("reset_tick", 16'(tick_out), 16'h0);
    chk("reset_status", status_data_out, 16'h0);
    chk("reset_period", period_data_out, 16'h0);
    @(negedge sysclk);
    sysreset_n = 1'b1;

    // Reset mid-run: P=5, tick at E5, then reset while tick_out is high.
    wr(1'b1, 1'b0, 16'd5);
    chk("period_5", period_data_out, 16'd5);
    exp_q.push_back(1'b0);
    wr(1'b0, 1'b1, 16'h1);
    push_trace(5, 5, 1'b0);
    drain();
    sysreset_n = 1'b0;
    #1;
    chk("async_rst_tick", 16'(tick_out), 16'h0);
    chk("async_rst_status", status_data_out, 16'h0);
    chk("async_rst_period", period_data_out, 16'h0);
    @(negedge sysclk);
    sysreset_n = 1'b1;
    push_zeros(10);
    drain();
    chk("post_rst_status", status_data_out, 16'h0);

    // Periodic P=4.
    wr(1'b1, 1'b0, 16'd4);
    exp_q.push_back(1'b0);
    wr(1'b0, 1'b1, 16'h1);
    push_trace(20, 4, 1'b0);
    drain();
    chk("periodic_status", status_data_out, 16'h9);
    exp_q.push_back(1'b0);
    wr(1'b0, 1'b1, 16'h0);
    push_zeros(6);
    drain();
    chk("disable_status", status_data_out, 16'h0);

    // Oneshot P=3.
    wr(1'b1, 1'b0, 16'd3);
    exp_q.push_back(1'b0);
    wr(1'b0, 1'b1, 16'h3);
    push_trace(23, 3, 1'b1);
    drain();
    chk("oneshot_status", status_data_out, 16'hA);

    // Period change while running: 6 -> 2 mid-count, then 2 -> 0.
    wr(1'b1, 1'b0, 16'd6);
    exp_q.push_back(1'b0);
    wr(1'b0, 1'b1, 16'h1);
    for (int k = 1; k <= 11; k++) begin
      exp_q.push_back((k == 6) || ((k > 6) && (((k - 6) % 2) == 0)));
    end
    cycle();
    cycle();
    wr(1'b1, 1'b0, 16'd2);
    drain();
    exp_q.push_back(1'b1);
    exp_q.push_back(1'b0);
    exp_q.push_back(1'b1);
    push_zeros(10);
    wr(1'b1, 1'b0, 16'd0);
    drain();
    chk("p0_status", status_data_out, 16'h8);
    chk("p0_period", period_data_out, 16'h0);

    // Enable with P=0 stays idle.
    exp_q.push_back(1'b0);
    wr(1'b0, 1'b1, 16'h1);
    push_zeros(10);
    drain();
    chk("p0_enable_status", status_data_out, 16'h0);

    // Simultaneous period and control write with 0x0003.
    exp_q.push_back(1'b0);
    wr(1'b1, 1'b1, 16'h3);
    chk("simul_period", period_data_out, 16'd3);
    chk("simul_status", status_data_out, 16'h3);
    push_trace(15, 3, 1'b1);
    drain();
    chk("simul_end_status", status_data_out, 16'hA);

    // Integration: rising edges consumed by a 10-count down counter, P=2.
    wr(1'b1, 1'b0, 16'd2);
    exp_q.push_back(1'b0);
    wr(1'b0, 1'b1, 16'h1);
    push_trace(22, 2, 1'b0);
    rises = 0;
    prev  = 1'b0;
    for (int i = 1; i <= 22; i++) begin
      cycle();
      if (tick_out && !prev) rises++;
      prev = tick_out;
      if (i == 19) chk("expired_e19", 16'(rises >= 10), 16'h0);
      if (i == 20) chk("expired_e20", 16'(rises >= 10), 16'h1);
    end
    chk("chain_status", status_data_out, 16'h9);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
